wb_rr_arbiter: RTL and testbench

Parametrised successor to the two-master CPU/SPI bus selector. It arbitrates NUM_MASTERS Wishbone classic masters onto one shared slave bus using round-robin priority. It holds the grant for the full cycle (cyc) and includes the bus-cycle watchdog that was previously missing. The watchdog acks a stalled access with a poison read value, so a bad address can no longer hang the CPU or the SPI bridge.

---
 rtl/wb_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter for NUM_MASTERS Wishbone classic masters sharing one slave.
// The grant is held for the owner's whole cyc. A bus-cycle watchdog force-acks a
// stalled access with a poison read value so a dead address cannot hang a master.
// The timeout pulse is registered, so it appears the cycle after the forced ack.
module wb_rr_arbiter #(
    parameter int          NUM_MASTERS = 2,
    parameter int          WDT_LIMIT   = 63,
    parameter int          WDT_BITS    = 7,
    parameter logic [31:0] POISON      = 32'hdeaddead
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst_n,
    input  logic [NUM_MASTERS-1:0]   m_cyc,
    input  logic [NUM_MASTERS-1:0]   m_stb,
    input  logic [NUM_MASTERS-1:0]   m_we,
    input  logic [4*NUM_MASTERS-1:0] m_sel,
    input  logic [32*NUM_MASTERS-1:0] m_adr,
    input  logic [32*NUM_MASTERS-1:0] m_dat,
    output logic [NUM_MASTERS-1:0]   m_ack,
    output logic [31:0]              m_rdt,
    output logic                     s_cyc,
    output logic                     s_stb,
    output logic                     s_we,
    output logic [3:0]               s_sel,
    output logic [31:0]              s_adr,
    output logic [31:0]              s_dat,
    input  logic                     s_ack,
    input  logic [31:0]              s_rdt,
    output logic [NUM_MASTERS-1:0]   grant,
    output logic                     timeout,
    output logic [7:0]               err_cnt
);

    localparam int                  IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [WDT_BITS-1:0] WDT_LIM = WDT_BITS'(WDT_LIMIT);
    localparam logic                WDT_EN  = (WDT_LIMIT != 0);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [WDT_BITS-1:0]    wdt_q, wdt_d;
    logic                   timeout_q;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0]       g_idx_s;
    logic                   grant_valid_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_found_s;
    logic                   wdt_active_s;
    logic                   wdt_fire_s;

    // Encode the one-hot registered grant into an index for the muxes.
    always_comb begin
        g_idx_s = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                g_idx_s = IDX_W'(i);
            end else begin
                g_idx_s = g_idx_s;
            end
        end
        grant_valid_s = |grant_q;
    end

    // Round-robin search for the first requester after the last owner.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!pick_found_s && m_cyc[(int'(last_q) + k) % NUM_MASTERS]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IDX_W'((int'(last_q) + k) % NUM_MASTERS);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Hold the grant while the owner keeps cyc, otherwise hand it to the next requester.
    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        if (grant_valid_s && m_cyc[g_idx_s]) begin
            grant_d = grant_q;
        end else if (pick_found_s) begin
            grant_d             = '0;
            grant_d[pick_idx_s] = 1'b1;
            last_d              = pick_idx_s;
        end else begin
            grant_d = '0;
        end
    end

    // Route the owner's controls to the slave; everything is zero when idle.
    always_comb begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_we  = 1'b0;
        s_sel = 4'h0;
        s_adr = 32'h0000_0000;
        s_dat = 32'h0000_0000;
        if (grant_valid_s) begin
            s_cyc = m_cyc[g_idx_s];
            s_stb = m_stb[g_idx_s];
            s_we  = m_we[g_idx_s];
            s_sel = m_sel[4*int'(g_idx_s) +: 4];
            s_adr = m_adr[32*int'(g_idx_s) +: 32];
            s_dat = m_dat[32*int'(g_idx_s) +: 32];
        end else begin
            s_cyc = 1'b0;
        end
    end

    // Watchdog fire condition; a real ack in the same cycle always wins.
    always_comb begin
        wdt_active_s = s_cyc & s_stb & ~s_ack;
        wdt_fire_s   = WDT_EN & wdt_active_s & (wdt_q == WDT_LIM);
    end

    // Return ack and read data to the owner only; the watchdog substitutes poison.
    always_comb begin
        m_ack          = '0;
        m_ack[g_idx_s] = (s_ack | wdt_fire_s) & grant_valid_s;
        if (wdt_fire_s) begin
            m_rdt = POISON;
        end else begin
            m_rdt = s_rdt;
        end
    end

    // Watchdog count restarts on ack, idle strobe, fire or ownership change.
    always_comb begin
        if (grant_d != grant_q) begin
            wdt_d = '0;
        end else if (wdt_fire_s) begin
            wdt_d = '0;
        end else if (wdt_active_s) begin
            wdt_d = wdt_q + {{(WDT_BITS-1){1'b0}}, 1'b1};
        end else begin
            wdt_d = '0;
        end
    end

    // Saturating timeout counter.
    always_comb begin
        if (wdt_fire_s && (err_cnt_q != 8'hff)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State registers; reset parks last on the top index so master 0 wins first.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_MASTERS - 1);
            wdt_q     <= '0;
            timeout_q <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            grant_q   <= grant_d;
            last_q    <= last_d;
            wdt_q     <= wdt_d;
            timeout_q <= wdt_fire_s;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign timeout = timeout_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench: a two-master instance for the main scenarios and a four-master
// instance with a short watchdog for rotation order and counter saturation.
module tb_wb_rr_arbiter;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    int          checks = 0;
    int          errors = 0;
    int          n;

    // Two-master instance
    logic [1:0]  a_m_cyc, a_m_stb, a_m_we, a_m_ack, a_grant;
    logic [7:0]  a_m_sel;
    logic [63:0] a_m_adr, a_m_dat;
    logic [31:0] a_m_rdt, a_s_adr, a_s_dat, a_s_rdt;
    logic        a_s_cyc, a_s_stb, a_s_we, a_s_ack, a_timeout;
    logic [3:0]  a_s_sel;
    logic [7:0]  a_err_cnt;

    // Four-master instance
    logic [3:0]   b_m_cyc, b_m_stb, b_m_we, b_m_ack, b_grant;
    logic [15:0]  b_m_sel;
    logic [127:0] b_m_adr, b_m_dat;
    logic [31:0]  b_m_rdt, b_s_adr, b_s_dat, b_s_rdt;
    logic         b_s_cyc, b_s_stb, b_s_we, b_s_ack, b_timeout;
    logic [3:0]   b_s_sel;
    logic [7:0]   b_err_cnt;

    always #5 wb_clk = ~wb_clk;

    wb_rr_arbiter #(.NUM_MASTERS(2), .WDT_LIMIT(63), .WDT_BITS(7), .POISON(32'hdeaddead)) dut_a (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m_cyc(a_m_cyc), .m_stb(a_m_stb), .m_we(a_m_we), .m_sel(a_m_sel),
        .m_adr(a_m_adr), .m_dat(a_m_dat), .m_ack(a_m_ack), .m_rdt(a_m_rdt),
        .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_sel(a_s_sel),
        .s_adr(a_s_adr), .s_dat(a_s_dat), .s_ack(a_s_ack), .s_rdt(a_s_rdt),
        .grant(a_grant), .timeout(a_timeout), .err_cnt(a_err_cnt)
    );

    wb_rr_arbiter #(.NUM_MASTERS(4), .WDT_LIMIT(2), .WDT_BITS(2), .POISON(32'hdeaddead)) dut_b (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m_cyc(b_m_cyc), .m_stb(b_m_stb), .m_we(b_m_we), .m_sel(b_m_sel),
        .m_adr(b_m_adr), .m_dat(b_m_dat), .m_ack(b_m_ack), .m_rdt(b_m_rdt),
        .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_sel(b_s_sel),
        .s_adr(b_s_adr), .s_dat(b_s_dat), .s_ack(b_s_ack), .s_rdt(b_s_rdt),
        .grant(b_grant), .timeout(b_timeout), .err_cnt(b_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk);
        @(negedge wb_clk);
    endtask

    initial begin
        wb_rst_n = 1'b0;
        a_m_cyc = 2'b00; a_m_stb = 2'b00; a_m_we = 2'b00; a_m_sel = 8'hff;
        a_m_adr = 64'h0; a_m_dat = 64'h0; a_s_ack = 1'b0; a_s_rdt = 32'h0;
        b_m_cyc = 4'h0; b_m_stb = 4'h0; b_m_we = 4'h0; b_m_sel = 16'hffff;
        b_m_adr = 128'h0; b_m_dat = 128'h0; b_s_ack = 1'b0; b_s_rdt = 32'h0;
        @(negedge wb_clk);
        step();
        chk("rst_grant", a_grant, 32'h0);
        chk("rst_s_cyc", a_s_cyc, 32'h0);
        chk("rst_err", a_err_cnt, 32'h0);
        chk("rst_timeout", a_timeout, 32'h0);
        wb_rst_n = 1'b1;

        // 1: single access from master 0, ack two cycles after grant
        a_m_cyc = 2'b01; a_m_stb = 2'b01; a_m_adr[31:0] = 32'h0000_0100;
        #1 chk("t1_pre_grant", a_s_cyc, 32'h0);
        step();
        chk("t1_grant", a_grant, 32'h1);
        chk("t1_s_cyc", a_s_cyc, 32'h1);
        chk("t1_s_adr", a_s_adr, 32'h0000_0100);
        step();
        a_s_ack = 1'b1; a_s_rdt = 32'h12345678;
        #1 chk("t1_ack", a_m_ack, 32'h1);
        chk("t1_rdt", a_m_rdt, 32'h12345678);
        step();
        a_s_ack = 1'b0; a_m_cyc = 2'b00; a_m_stb = 2'b00;
        step();
        chk("t1_idle", a_grant, 32'h0);

        // 2: both masters contend; last owner was 0, so master 1 goes first
        a_m_adr = {32'h0000_00b0, 32'h0000_00a0};
        a_m_cyc = 2'b11; a_m_stb = 2'b11;
        step();
        for (int i = 0; i < 6; i++) begin
            logic [1:0] g;
            g = (i % 2 == 0) ? 2'b10 : 2'b01;
            chk("t2_grant", a_grant, {30'h0, g});
            chk("t2_s_adr", a_s_adr, (g == 2'b10) ? 32'h0000_00b0 : 32'h0000_00a0);
            a_s_ack = 1'b1;
            #1 chk("t2_ack", a_m_ack, {30'h0, g});
            step();
            a_s_ack = 1'b0;
            a_m_cyc = 2'b11 & ~g;
            a_m_stb = 2'b11 & ~g;
            step();
            a_m_cyc = 2'b11; a_m_stb = 2'b11;
        end
        a_m_cyc = 2'b00; a_m_stb = 2'b00;
        step();
        chk("t2_idle", a_grant, 32'h0);

        // 3: master 1 hits a dead address; watchdog fires 64 edges after stb
        a_m_cyc = 2'b10; a_m_stb = 2'b10; a_m_adr[63:32] = 32'h0000_0bad;
        n = 0;
        while (a_m_ack[1] == 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("t3_latency", n, 32'd64);
        chk("t3_poison", a_m_rdt, 32'hdeaddead);
        chk("t3_ack0_quiet", {31'h0, a_m_ack[0]}, 32'h0);
        chk("t3_err_before", a_err_cnt, 32'h0);
        step();
        chk("t3_timeout", a_timeout, 32'h1);
        chk("t3_err", a_err_cnt, 32'h1);
        chk("t3_no_reack", a_m_ack, 32'h0);
        step();
        chk("t3_timeout_end", a_timeout, 32'h0);

        // 4: real ack on the cycle wdt reaches the limit wins over the watchdog
        a_m_cyc = 2'b00; a_m_stb = 2'b00;
        step();
        a_m_cyc = 2'b10; a_m_stb = 2'b10;
        for (int i = 0; i < 64; i++) step();
        #1 chk("t4_would_fire", a_m_rdt, 32'hdeaddead);
        a_s_ack = 1'b1; a_s_rdt = 32'hcafef00d;
        #1 chk("t4_ack", a_m_ack, 32'h2);
        chk("t4_rdt", a_m_rdt, 32'hcafef00d);
        step();
        chk("t4_timeout", a_timeout, 32'h0);
        chk("t4_err", a_err_cnt, 32'h1);
        a_s_ack = 1'b0; a_m_cyc = 2'b00; a_m_stb = 2'b00;
        step();

        // 5: reset during master 1 access drops the grant asynchronously
        a_m_cyc = 2'b10; a_m_stb = 2'b10;
        step();
        chk("t5_grant", a_grant, 32'h2);
        chk("t5_s_cyc", a_s_cyc, 32'h1);
        #2 wb_rst_n = 1'b0;
        #1 chk("t5_rst_grant", a_grant, 32'h0);
        chk("t5_rst_s_cyc", a_s_cyc, 32'h0);
        chk("t5_rst_err", a_err_cnt, 32'h0);
        step();
        wb_rst_n = 1'b1;
        a_m_cyc = 2'b11; a_m_stb = 2'b11;
        step();
        chk("t5_m0_wins", a_grant, 32'h1);
        a_m_cyc = 2'b00; a_m_stb = 2'b00;

        // 6: four masters, all requesting, each released after one forced ack
        b_m_cyc = 4'hf; b_m_stb = 4'hf;
        step();
        for (int i = 0; i < 256; i++) begin
            logic [3:0] g;
            n = 0;
            while (b_m_ack == 4'h0 && n < 10) begin
                step();
                n++;
            end
            if (n >= 10) begin
                chk("t6_ack_wait", 32'h0, 32'h1);
                break;
            end
            if (i < 5) begin
                chk("t6_grant", b_grant, 32'h1 << (i % 4));
                chk("t6_ack_owner", b_m_ack, 32'h1 << (i % 4));
            end
            if (i == 0) chk("t6_poison", b_m_rdt, 32'hdeaddead);
            if (i == 200) chk("t6_err_200", b_err_cnt, 32'd200);
            if (i == 255) chk("t6_err_255", b_err_cnt, 32'd255);
            g = b_grant;
            step();
            b_m_cyc = 4'hf & ~g; b_m_stb = 4'hf & ~g;
            step();
            b_m_cyc = 4'hf; b_m_stb = 4'hf;
        end
        b_m_cyc = 4'h0; b_m_stb = 4'h0;
        step();
        chk("t6_err_sat", b_err_cnt, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
